// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

    // Arbiter sequencing: one transaction in flight at a time.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Which upstream port owns the transaction currently in flight.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IFU  = 2'd1,
        OWN_LSU  = 2'd2
    } owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Read data returned to the owner when the memory never answers.
    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle between the cpu ports (ifu, lsu), the arbiter and the memory.
// The master modport is the arbiter's view; the slave modport is the
// view of whatever sits around it (cpu ports plus memory).
//
// Handshake rules on this bus:
//   - ifu_reqValid / lsu_reqValid are levels: a port holds its request and
//     fields stable until its transaction is granted; after its respValid a
//     still-high reqValid is a new transaction.
//   - ifu_respValid / lsu_respValid are single-cycle strobes qualifying rdata.
//   - mem_reqValid is held with stable mem_* fields until mem_reqReady is
//     seen high on a clock edge; that edge is the transfer.
//   - mem_respValid is a single-cycle strobe qualifying mem_rdata and is only
//     honoured while a request is outstanding.
interface mem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            ifu_reqValid;
    logic [AW-1:0]   ifu_addr;
    logic            ifu_respValid;
    logic [DW-1:0]   ifu_rdata;

    logic            lsu_reqValid;
    logic [AW-1:0]   lsu_addr;
    logic [1:0]      lsu_size;
    logic            lsu_wen;
    logic [DW-1:0]   lsu_wdata;
    logic [DW/8-1:0] lsu_wmask;
    logic            lsu_respValid;
    logic [DW-1:0]   lsu_rdata;

    logic            mem_reqValid;
    logic            mem_reqReady;
    logic [AW-1:0]   mem_addr;
    logic [1:0]      mem_size;
    logic            mem_wen;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wmask;
    logic            mem_respValid;
    logic [DW-1:0]   mem_rdata;

    logic            bus_err;

    modport master (
        input  ifu_reqValid, ifu_addr,
        output ifu_respValid, ifu_rdata,
        input  lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_respValid, lsu_rdata,
        output mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
        input  mem_reqReady, mem_respValid, mem_rdata,
        output bus_err
    );

    modport slave (
        output ifu_reqValid, ifu_addr,
        input  ifu_respValid, ifu_rdata,
        output lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_respValid, lsu_rdata,
        input  mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
        output mem_reqReady, mem_respValid, mem_rdata,
        input  bus_err
    );

endinterface

// File: rtl/mem_arb_timer.sv
// Outstanding-request watchdog for mem_arb. Counts cycles spent waiting on
// memory and flags expiry on the TIMEOUT_CYC-th waiting cycle. Only
// instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] cnt_q;

    assign expired = run & (cnt_q == CW'(TIMEOUT_CYC - 1));

    // Wait-cycle counter: zeroed as a request is granted, parks once expired.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Two-master (ifu, lsu), one-slave memory arbiter. One transaction in
// flight; request fields are latched at grant, the response is registered
// and handed back to the owning port as a one-cycle strobe. lsu wins ties.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to force an error response
// (ERR_RDATA, bus_err) after TIMEOUT_CYC cycles without a memory response.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic      clock,
    input  logic      reset_n,
    mem_arb_if.master bus,
    output state_t    dbg_state,
    output owner_t    dbg_owner
);
    state_t state_q, state_d;
    owner_t owner_q;

    logic [AW-1:0]   addr_q;
    logic [1:0]      size_q;
    logic            wen_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] wmask_q;

    logic [DW-1:0]   rdata_q;
    logic            err_q;

    logic any_req;
    logic in_flight;
    logic rsp_take;
    logic timeout_hit;
    logic ifu_resp;
    logic lsu_resp;

    assign any_req   = bus.ifu_reqValid | bus.lsu_reqValid;
    assign in_flight = (state_q == ST_REQ) | (state_q == ST_WAIT);
    // A response counts only while a request is outstanding; in REQ it must
    // coincide with the acceptance of the request itself.
    assign rsp_take  = bus.mem_respValid &
                       (((state_q == ST_REQ) & bus.mem_reqReady) | (state_q == ST_WAIT));

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   ((state_q == ST_IDLE) & any_req),
        .run     (in_flight),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a real response beats the watchdog when both land together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (rsp_take || timeout_hit) state_d = ST_RESP;
                else if (bus.mem_reqReady)   state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (rsp_take || timeout_hit) state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grant: latch the winner's fields; ifu fetches are full-word reads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= OWN_NONE;
            addr_q  <= '0;
            size_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (state_q == ST_IDLE && bus.lsu_reqValid) begin
            owner_q <= OWN_LSU;
            addr_q  <= bus.lsu_addr;
            size_q  <= bus.lsu_size;
            wen_q   <= bus.lsu_wen;
            wdata_q <= bus.lsu_wdata;
            wmask_q <= bus.lsu_wmask;
        end else if (state_q == ST_IDLE && bus.ifu_reqValid) begin
            owner_q <= OWN_IFU;
            addr_q  <= bus.ifu_addr;
            size_q  <= SIZE_WORD;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '1;
        end else if (state_q == ST_RESP) begin
            owner_q <= OWN_NONE;
        end
    end

    // Response capture: stores return zero data, a watchdog expiry returns
    // the error pattern and flags bus_err.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (rsp_take) begin
            rdata_q <= wen_q ? '0 : bus.mem_rdata;
            err_q   <= 1'b0;
        end else if (timeout_hit) begin
            rdata_q <= DW'(ERR_RDATA);
            err_q   <= 1'b1;
        end
    end

    assign ifu_resp = (state_q == ST_RESP) & (owner_q == OWN_IFU);
    assign lsu_resp = (state_q == ST_RESP) & (owner_q == OWN_LSU);

    assign bus.mem_reqValid  = (state_q == ST_REQ);
    assign bus.mem_addr      = addr_q;
    assign bus.mem_size      = size_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wmask     = wmask_q;

    assign bus.ifu_respValid = ifu_resp;
    assign bus.ifu_rdata     = ifu_resp ? rdata_q : '0;
    assign bus.lsu_respValid = lsu_resp;
    assign bus.lsu_rdata     = lsu_resp ? rdata_q : '0;
    assign bus.bus_err       = (state_q == ST_RESP) & err_q;

    assign dbg_state = state_q;
    assign dbg_owner = owner_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios followed by randomized
// transactions, checked against a transaction-level scoreboard.
module tb_mem_arb;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TCYC = 8;
`else
    localparam int TCYC = 255;
`endif

    typedef struct packed {
        owner_t      own;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    typedef struct packed {
        owner_t      own;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic   clock   = 1'b0;
    logic   reset_n = 1'b1;
    state_t dbg_state;
    owner_t dbg_owner;

    mem_arb_if #(.AW(AW), .DW(DW)) bus ();

    mem_arb #(
        .AW(AW), .DW(DW), .TIMEOUT_CYC(TCYC)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus.master),
        .dbg_state (dbg_state),
        .dbg_owner (dbg_owner)
    );

    // clock / reset
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // scoreboard: expected memory requests in grant order, expected responses
    req_t exp_q[$];
    rsp_t rsp_q[$];
    logic [31:0] mem_model [logic [29:0]];

    int ifu_left = 0;
    int lsu_left = 0;
    int n_resp   = 0;

    // memory responder knobs and counters
    int rdy_knob = 0, rsp_knob = 0;
    int rdy_cnt = 0, rsp_cnt = 0, hi_cnt = 0;
    bit pend = 0;
    logic [31:0] pend_data = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a[31:2])) return mem_model[a[31:2]];
        return {a[15:0] ^ 16'hC3A5, a[31:16]};
    endfunction

    task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] w;
        w = mem_read(a);
        for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
        mem_model[a[31:2]] = w;
    endtask

    task automatic set_knobs(input int r, input int s);
        rdy_knob = r; rsp_knob = s; rdy_cnt = r; hi_cnt = 0;
    endtask

    // Behavioural memory: checks held request fields every cycle against the
    // next expected grant, accepts after rdy_knob stall cycles, answers after
    // rsp_knob further cycles (0 = same cycle as acceptance).
    task automatic slave_cycle();
        req_t e;
        logic [31:0] rd;
        bus.mem_reqReady  = 1'b0;
        bus.mem_respValid = 1'b0;
        bus.mem_rdata     = $urandom;
        if (bus.mem_reqValid) begin
            if (exp_q.size() == 0) begin
                check("mem_req_unexpected", bus.mem_reqValid, 1'b0);
            end else begin
                e = exp_q[0];
                check("mem_addr",  bus.mem_addr,  e.addr);
                check("mem_size",  bus.mem_size,  e.size);
                check("mem_wen",   bus.mem_wen,   e.wen);
                check("mem_wdata", bus.mem_wdata, e.wdata);
                check("mem_wmask", bus.mem_wmask, e.wmask);
                hi_cnt++;
                if (rdy_cnt > 0) begin
                    rdy_cnt--;
                end else begin
                    bus.mem_reqReady = 1'b1;
                    check("mem_req_hold_cycles", hi_cnt, rdy_knob + 1);
                    hi_cnt  = 0;
                    rdy_cnt = rdy_knob;
                    void'(exp_q.pop_front());
                    rd = mem_read(e.addr);
                    if (e.wen) mem_write(e.addr, e.wdata, e.wmask);
                    rsp_q.push_back('{own: e.own, data: (e.wen ? 32'h0 : rd), err: 1'b0});
                    // once granted, a port's own fields no longer matter
                    if (e.own == OWN_LSU && lsu_left == 1) begin
                        bus.lsu_addr  = $urandom;
                        bus.lsu_wdata = $urandom;
                        bus.lsu_wmask = 4'($urandom);
                        bus.lsu_size  = 2'($urandom_range(0, 3));
                        bus.lsu_wen   = 1'($urandom);
                    end
                    if (e.own == OWN_IFU && ifu_left == 1) bus.ifu_addr = $urandom;
                    if (rsp_knob == 0) begin
                        bus.mem_respValid = 1'b1;
                        bus.mem_rdata     = rd;
                    end else begin
                        pend = 1; pend_data = rd; rsp_cnt = rsp_knob;
                    end
                end
            end
        end else if (pend) begin
            if (rsp_cnt > 1) begin
                rsp_cnt--;
            end else begin
                bus.mem_respValid = 1'b1;
                bus.mem_rdata     = pend_data;
                pend = 0;
            end
        end
    endtask

    // One clock: sample at the falling edge, score responses, drive memory.
    task automatic cycle();
        rsp_t r;
        @(negedge clock);
        if (bus.ifu_respValid || bus.lsu_respValid) begin
            check("req_resp_overlap", bus.mem_reqValid, 1'b0);
            if (rsp_q.size() == 0) begin
                check("resp_unexpected", {bus.ifu_respValid, bus.lsu_respValid}, 2'b00);
            end else begin
                r = rsp_q.pop_front();
                check("resp_owner", {bus.ifu_respValid, bus.lsu_respValid},
                      (r.own == OWN_IFU) ? 2'b10 : 2'b01);
                check("resp_rdata", bus.ifu_respValid ? bus.ifu_rdata : bus.lsu_rdata, r.data);
                check("resp_bus_err", bus.bus_err, r.err);
                n_resp++;
            end
            if (bus.ifu_respValid) begin
                ifu_left--;
                if (ifu_left <= 0) bus.ifu_reqValid = 1'b0;
            end
            if (bus.lsu_respValid) begin
                lsu_left--;
                if (lsu_left <= 0) bus.lsu_reqValid = 1'b0;
            end
        end
        slave_cycle();
    endtask

    task automatic clear_inputs();
        bus.ifu_reqValid = 0; bus.ifu_addr = '0;
        bus.lsu_reqValid = 0; bus.lsu_addr = '0; bus.lsu_size = '0; bus.lsu_wen = 0;
        bus.lsu_wdata = '0; bus.lsu_wmask = '0;
        bus.mem_reqReady = 0; bus.mem_respValid = 0; bus.mem_rdata = '0;
        exp_q.delete(); rsp_q.delete();
        ifu_left = 0; lsu_left = 0; pend = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Requests are queued in the order the arbiter must grant them: callers
    // launch lsu before ifu because lsu wins simultaneous requests.
    task automatic launch_lsu(input logic [31:0] a, input logic [1:0] sz, input logic we,
                              input logic [31:0] wd, input logic [3:0] wm);
        req_t e;
        bus.lsu_reqValid = 1'b1; bus.lsu_addr = a; bus.lsu_size = sz;
        bus.lsu_wen = we; bus.lsu_wdata = wd; bus.lsu_wmask = wm;
        lsu_left = 1;
        e.own = OWN_LSU; e.addr = a; e.size = sz; e.wen = we; e.wdata = wd; e.wmask = wm;
        exp_q.push_back(e);
    endtask

    task automatic launch_ifu(input logic [31:0] a, input int n);
        req_t e;
        bus.ifu_reqValid = 1'b1; bus.ifu_addr = a;
        ifu_left = n;
        e.own = OWN_IFU; e.addr = a; e.size = SIZE_WORD; e.wen = 1'b0;
        e.wdata = 32'h0; e.wmask = 4'hF;
        for (int k = 0; k < n; k++) exp_q.push_back(e);
    endtask

    // Run until every queued transaction has been answered; lat is the
    // number of cycles to the first response.
    task automatic run(input int max_cyc, output int lat);
        int i;
        int n0;
        lat = -1; i = 0; n0 = n_resp;
        while (exp_q.size() != 0 || rsp_q.size() != 0) begin
            if (i >= max_cyc) begin
                check("txn_done_in_budget", exp_q.size() + rsp_q.size(), 0);
                do_reset();
                break;
            end
            cycle();
            i++;
            if (lat < 0 && n_resp != n0) lat = i;
        end
    endtask

    initial begin
        int lat;
        int n0;
        clear_inputs();
        #1 reset_n = 1'b0;
        #2;
        // reset state
        check("rst_state",     dbg_state,         ST_IDLE);
        check("rst_owner",     dbg_owner,         OWN_NONE);
        check("rst_mem_req",   bus.mem_reqValid,  1'b0);
        check("rst_mem_addr",  bus.mem_addr,      32'h0);
        check("rst_mem_size",  bus.mem_size,      2'd0);
        check("rst_mem_wen",   bus.mem_wen,       1'b0);
        check("rst_mem_wdata", bus.mem_wdata,     32'h0);
        check("rst_mem_wmask", bus.mem_wmask,     4'h0);
        check("rst_resp",      {bus.ifu_respValid, bus.lsu_respValid, bus.bus_err}, 3'b000);
        check("rst_rdata",     {bus.ifu_rdata, bus.lsu_rdata}, 64'h0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        cycle();
        check("idle_after_rst", dbg_state, ST_IDLE);

        // 1: single ifu fetch, same-cycle accept and response
        mem_model[30'h2000_0000] = 32'h0000_0013;
        set_knobs(0, 0);
        launch_ifu(32'h8000_0000, 1);
        run(20, lat);
        check("ifu_min_latency", lat, 2);
        cycle();
        check("mem_addr_hold_idle", bus.mem_addr,  32'h8000_0000);
        check("mem_wmask_hold_idle", bus.mem_wmask, 4'hF);

        // 2: simultaneous requests, lsu first then ifu
        mem_model[30'h40] = 32'h1111_2222;
        mem_model[30'h2000_0001] = 32'h3333_4444;
        launch_lsu(32'h100, SIZE_WORD, 1'b0, 32'h0, 4'hF);
        launch_ifu(32'h8000_0004, 1);
        run(40, lat);
        check("lsu_first_latency", lat, 2);
        cycle();

        // 3+4: stalled half-word store; lsu_addr changes after grant
        set_knobs(5, 2);
        launch_lsu(32'h104, SIZE_HALF, 1'b1, 32'hAABB_CCDD, 4'b0011);
        cycle();
        bus.lsu_addr = 32'h200;
        run(40, lat);
        check("store_latency", lat + 1, 9);
        cycle();

        // held ifu level after its response is a second transaction
        set_knobs(1, 1);
        launch_ifu(32'h8000_0040, 2);
        run(40, lat);
        cycle();

        // 5: reset while waiting on memory, then a stray response
        set_knobs(0, 50);
        launch_lsu(32'h108, SIZE_WORD, 1'b0, 32'h0, 4'hF);
        cycle();
        cycle();
        check("pre_rst_in_wait", dbg_state, ST_WAIT);
        reset_n = 1'b0;
        #1;
        check("async_rst_state", dbg_state, ST_IDLE);
        check("async_rst_mem_req", bus.mem_reqValid, 1'b0);
        clear_inputs();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        bus.mem_respValid = 1'b1;
        bus.mem_rdata     = 32'h5555_AAAA;
        @(negedge clock);
        check("stray_no_resp", {bus.ifu_respValid, bus.lsu_respValid}, 2'b00);
        check("stray_state", dbg_state, ST_IDLE);
        bus.mem_respValid = 1'b0;
        n0 = n_resp;
        repeat (3) cycle();
        check("stray_no_late_resp", n_resp, n0);

        // 6: memory that never answers
        set_knobs(0, 100000);
        launch_ifu(32'h8000_0080, 1);
`ifdef MEM_ARB_TIMEOUT_EN
        cycle();
        if (rsp_q.size() != 0) rsp_q[0] = '{own: OWN_IFU, data: 32'hDEAD_BEEF, err: 1'b1};
        run(30, lat);
        check("timeout_latency", lat + 1, 9);
        rsp_cnt = 1;
        n0 = n_resp;
        repeat (3) cycle();
        check("timeout_stray_ignored", n_resp, n0);
        check("timeout_back_idle", dbg_state, ST_IDLE);
`else
        n0 = n_resp;
        repeat (1000) cycle();
        check("no_timeout_no_resp", n_resp, n0);
        check("no_timeout_waiting", dbg_state, ST_WAIT);
        check("no_timeout_bus_err", bus.bus_err, 1'b0);
        rsp_cnt = 1;
        run(10, lat);
        check("late_resp_latency", lat, 2);
`endif
        cycle();

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            bit di, dl;
            di = 1'($urandom_range(0, 1));
            dl = 1'($urandom_range(0, 1));
            if (!di && !dl) dl = 1'b1;
            set_knobs($urandom_range(0, 3), $urandom_range(0, 3));
            if (dl) launch_lsu(32'h100 + {26'($urandom_range(0, 15)), 2'b00},
                               2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                               $urandom, 4'($urandom));
            if (di) launch_ifu(32'h8000_0000 + {26'($urandom_range(0, 63)), 2'b00},
                               $urandom_range(1, 2));
            run(200, lat);
            if ($urandom_range(0, 1) == 1) cycle();
        end
        cycle();
        check("final_idle", dbg_state, ST_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
